// File: rtl/mmu_tlb.sv
// ---------------------------------------------------------------------------
// mmu_tlb -- fully associative MIPS-style TLB with two combinational lookup
// ports, a registered probe port, a write port and a combinational read port.
//
// Ports
//   clk, reset            : single clock, synchronous active-high reset
//   s0_* / s1_*           : lookup ports (fetch / data). Inputs vpn2, odd_page,
//                           asid; outputs found, index, pfn, c, d, v, valid in
//                           the same cycle as the request.
//   p_req, p_vpn2, p_asid : probe request, sampled at the rising edge
//   p_done/p_found/p_index: registered probe result; p_done pulses one cycle
//   we, w_index, w_*      : entry write, applied at the rising edge
//   r_index, r_*          : combinational read of one entry
//
// Every lookup, probe and read sees the contents held before any write in
// the same cycle. Multiple matching entries resolve to the lowest index.
// ---------------------------------------------------------------------------
module mmu_tlb #(
  parameter  int TLBNUM = 16,
  localparam int IDXW   = (TLBNUM > 1) ? $clog2(TLBNUM) : 1
) (
  input  logic            clk,
  input  logic            reset,
  // lookup port 0 (fetch)
  input  logic [18:0]     s0_vpn2,
  input  logic            s0_odd_page,
  input  logic [7:0]      s0_asid,
  output logic            s0_found,
  output logic [IDXW-1:0] s0_index,
  output logic [19:0]     s0_pfn,
  output logic [2:0]      s0_c,
  output logic            s0_d,
  output logic            s0_v,
  // lookup port 1 (data)
  input  logic [18:0]     s1_vpn2,
  input  logic            s1_odd_page,
  input  logic [7:0]      s1_asid,
  output logic            s1_found,
  output logic [IDXW-1:0] s1_index,
  output logic [19:0]     s1_pfn,
  output logic [2:0]      s1_c,
  output logic            s1_d,
  output logic            s1_v,
  // probe port
  input  logic            p_req,
  input  logic [18:0]     p_vpn2,
  input  logic [7:0]      p_asid,
  output logic            p_done,
  output logic            p_found,
  output logic [IDXW-1:0] p_index,
  // write port
  input  logic            we,
  input  logic [IDXW-1:0] w_index,
  input  logic [18:0]     w_vpn2,
  input  logic [7:0]      w_asid,
  input  logic            w_g,
  input  logic [19:0]     w_pfn0,
  input  logic [2:0]      w_c0,
  input  logic            w_d0,
  input  logic            w_v0,
  input  logic [19:0]     w_pfn1,
  input  logic [2:0]      w_c1,
  input  logic            w_d1,
  input  logic            w_v1,
  // read port
  input  logic [IDXW-1:0] r_index,
  output logic [18:0]     r_vpn2,
  output logic [7:0]      r_asid,
  output logic            r_g,
  output logic [19:0]     r_pfn0,
  output logic [2:0]      r_c0,
  output logic            r_d0,
  output logic            r_v0,
  output logic [19:0]     r_pfn1,
  output logic [2:0]      r_c1,
  output logic            r_d1,
  output logic            r_v1
);

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  tlb_entry_t entry_q [TLBNUM];
  tlb_entry_t entry_d [TLBNUM];
  tlb_entry_t w_entry;

  logic            p_done_q,  p_done_d;
  logic            p_found_q, p_found_d;
  logic [IDXW-1:0] p_index_q, p_index_d;

  logic [TLBNUM-1:0] s0_match, s1_match, p_match;
  logic [IDXW-1:0]   p_hit_index;
  tlb_entry_t        s0_sel, s1_sel;

  // Lowest set bit wins, so duplicate entries resolve deterministically.
  function automatic logic [IDXW-1:0] lowest_index(input logic [TLBNUM-1:0] m);
    lowest_index = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (m[i]) lowest_index = IDXW'(i);
    end
  endfunction

  assign w_entry = '{vpn2: w_vpn2, asid: w_asid, g: w_g,
                     pfn0: w_pfn0, c0: w_c0, d0: w_d0, v0: w_v0,
                     pfn1: w_pfn1, c1: w_c1, d1: w_d1, v1: w_v1};

  // A match ignores the V bit: invalid entries still hit so the pipeline can
  // raise TLB-invalid rather than TLB-refill.
  always_comb begin
    s0_match = '0;
    s1_match = '0;
    p_match  = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      s0_match[i] = (entry_q[i].vpn2 == s0_vpn2) &&
                    (entry_q[i].g || entry_q[i].asid == s0_asid);
      s1_match[i] = (entry_q[i].vpn2 == s1_vpn2) &&
                    (entry_q[i].g || entry_q[i].asid == s1_asid);
      p_match[i]  = (entry_q[i].vpn2 == p_vpn2) &&
                    (entry_q[i].g || entry_q[i].asid == p_asid);
    end
  end

  // Lookup port 0
  assign s0_found = |s0_match;
  assign s0_index = lowest_index(s0_match);
  assign s0_sel   = entry_q[s0_index];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the block leaves it unassigned, which would infer a latch.
    s0_pfn = '0;
    s0_c   = '0;
    s0_d   = 1'b0;
    s0_v   = 1'b0;
    if (s0_found) begin
      s0_pfn = s0_odd_page ? s0_sel.pfn1 : s0_sel.pfn0;
      s0_c   = s0_odd_page ? s0_sel.c1   : s0_sel.c0;
      s0_d   = s0_odd_page ? s0_sel.d1   : s0_sel.d0;
      s0_v   = s0_odd_page ? s0_sel.v1   : s0_sel.v0;
    end
  end

  // Lookup port 1
  assign s1_found = |s1_match;
  assign s1_index = lowest_index(s1_match);
  assign s1_sel   = entry_q[s1_index];

  always_comb begin
    s1_pfn = '0;
    s1_c   = '0;
    s1_d   = 1'b0;
    s1_v   = 1'b0;
    if (s1_found) begin
      s1_pfn = s1_odd_page ? s1_sel.pfn1 : s1_sel.pfn0;
      s1_c   = s1_odd_page ? s1_sel.c1   : s1_sel.c0;
      s1_d   = s1_odd_page ? s1_sel.d1   : s1_sel.d0;
      s1_v   = s1_odd_page ? s1_sel.v1   : s1_sel.v0;
    end
  end

  // Read port: plain combinational view of the stored entry.
  assign r_vpn2 = entry_q[r_index].vpn2;
  assign r_asid = entry_q[r_index].asid;
  assign r_g    = entry_q[r_index].g;
  assign r_pfn0 = entry_q[r_index].pfn0;
  assign r_c0   = entry_q[r_index].c0;
  assign r_d0   = entry_q[r_index].d0;
  assign r_v0   = entry_q[r_index].v0;
  assign r_pfn1 = entry_q[r_index].pfn1;
  assign r_c1   = entry_q[r_index].c1;
  assign r_d1   = entry_q[r_index].d1;
  assign r_v1   = entry_q[r_index].v1;

  // Next-state: entry write and probe capture. The probe match is taken from
  // entry_q, so a same-cycle write is not yet visible to it.
  assign p_hit_index = lowest_index(p_match);

  always_comb begin
    entry_d = entry_q;
    if (we) entry_d[w_index] = w_entry;

    // Result registers hold until the next probe completes.
    p_done_d  = p_req;
    p_found_d = p_found_q;
    p_index_d = p_index_q;
    if (p_req) begin
      p_found_d = |p_match;
      p_index_d = p_hit_index;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge value, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the entry array is reset as well, because the all-zero contents
      // after reset are architecturally visible through lookups and reads.
      for (int i = 0; i < TLBNUM; i++) entry_q[i] <= '0;
      p_done_q  <= 1'b0;
      p_found_q <= 1'b0;
      p_index_q <= '0;
    end else begin
      entry_q   <= entry_d;
      p_done_q  <= p_done_d;
      p_found_q <= p_found_d;
      p_index_q <= p_index_d;
    end
  end

  assign p_done  = p_done_q;
  assign p_found = p_found_q;
  assign p_index = p_index_q;

endmodule

// File: tb/tb_mmu_tlb.sv
// ---------------------------------------------------------------------------
// tb_mmu_tlb -- self-checking bench for mmu_tlb. Directed scenarios plus a
// randomized phase, all checked against a table-of-entries reference model
// that is updated once per rising edge.
// ---------------------------------------------------------------------------
module tb_mmu_tlb;

  logic        clk = 1'b0;
  logic        reset;
  logic [18:0] s0_vpn2, s1_vpn2, p_vpn2, w_vpn2, r_vpn2;
  logic        s0_odd_page, s1_odd_page;
  logic [7:0]  s0_asid, s1_asid, p_asid, w_asid, r_asid;
  logic        s0_found, s1_found, s0_d, s1_d, s0_v, s1_v;
  logic [3:0]  s0_index, s1_index, p_index, w_index, r_index;
  logic [19:0] s0_pfn, s1_pfn, w_pfn0, w_pfn1, r_pfn0, r_pfn1;
  logic [2:0]  s0_c, s1_c, w_c0, w_c1, r_c0, r_c1;
  logic        p_req, p_done, p_found;
  logic        we, w_g, w_d0, w_v0, w_d1, w_v1;
  logic        r_g, r_d0, r_v0, r_d1, r_v1;

  always #5 clk = ~clk;

  mmu_tlb #(.TLBNUM(16)) dut (
    .clk(clk), .reset(reset),
    .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
    .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
    .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
    .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
    .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
    .p_req(p_req), .p_vpn2(p_vpn2), .p_asid(p_asid),
    .p_done(p_done), .p_found(p_found), .p_index(p_index),
    .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
    .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
    .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
    .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1)
  );

  // Reference model: field order matches the r_* concatenation below.
  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } ent_t;

  ent_t       model [16];
  logic       exp_p_done, exp_p_found;
  logic [3:0] exp_p_index;
  int         n_checks = 0;
  int         n_fail   = 0;

  // Search the table for the first entry whose vpn2 matches and whose ASID
  // matches or is global.
  function automatic void ref_search(input logic [18:0] vpn2, input logic [7:0] asid,
                                     output logic hit, output logic [3:0] idx);
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (!hit && model[i].vpn2 == vpn2 && (model[i].g || model[i].asid == asid)) begin
        hit = 1'b1;
        idx = 4'(i);
      end
    end
  endfunction

  // Expected {found, index, pfn, c, d, v} of a lookup port.
  function automatic logic [29:0] ref_lookup(input logic [18:0] vpn2, input logic odd,
                                             input logic [7:0] asid);
    logic hit;
    logic [3:0] idx;
    ent_t e;
    ref_search(vpn2, asid, hit, idx);
    e = model[idx];
    if (!hit) return '0;
    if (odd) return {1'b1, idx, e.pfn1, e.c1, e.d1, e.v1};
    return {1'b1, idx, e.pfn0, e.c0, e.d0, e.v0};
  endfunction

  // One rising edge: the model takes the edge exactly as the spec describes
  // (reset wins; probe sees old contents; then the write lands).
  task automatic tick();
    logic hit;
    logic [3:0] idx;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 16; i++) model[i] = '0;
      exp_p_done  = 1'b0;
      exp_p_found = 1'b0;
      exp_p_index = '0;
    end else begin
      exp_p_done = p_req;
      if (p_req) begin
        ref_search(p_vpn2, p_asid, hit, idx);
        exp_p_found = hit;
        exp_p_index = idx;
      end
      if (we) model[w_index] = '{vpn2: w_vpn2, asid: w_asid, g: w_g,
                                 pfn0: w_pfn0, c0: w_c0, d0: w_d0, v0: w_v0,
                                 pfn1: w_pfn1, c1: w_c1, d1: w_d1, v1: w_v1};
    end
    #1;
  endtask

  task automatic set_write(input logic [3:0] idx, input logic [18:0] vpn2,
                           input logic [7:0] asid, input logic g,
                           input logic [19:0] pfn0, input logic [2:0] c0,
                           input logic d0, input logic v0,
                           input logic [19:0] pfn1, input logic [2:0] c1,
                           input logic d1, input logic v1);
    we = 1'b1; w_index = idx; w_vpn2 = vpn2; w_asid = asid; w_g = g;
    w_pfn0 = pfn0; w_c0 = c0; w_d0 = d0; w_v0 = v0;
    w_pfn1 = pfn1; w_c1 = c1; w_d1 = d1; w_v1 = v1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_write(4'd5, 19'h1, 8'h1, 1'b1, 20'h5, 3'd1, 1'b1, 1'b1, 20'h6, 3'd1, 1'b1, 1'b1);
    p_req = 1'b1;
    tick();
    tick();
    reset = 1'b0; we = 1'b0; p_req = 1'b0;
    s0_vpn2 = '0; s0_asid = '0; s0_odd_page = 1'b0;
    s1_vpn2 = 19'h1; s1_asid = 8'h1; s1_odd_page = 1'b0;
    r_index = 4'd5;
    #1;
    n_checks++;
    if ({p_done, p_found, p_index} !== 6'b0) begin
      $display("FAIL reset_probe: got %b want 000000", {p_done, p_found, p_index});
      n_fail++;
    end
    n_checks++;
    if ({s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v} !== {1'b1, 29'b0}) begin
      $display("FAIL reset_zero_lookup: got %h want %h",
               {s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v}, {1'b1, 29'b0});
      n_fail++;
    end
    n_checks++;
    if ({s1_found, s1_index, s1_pfn} !== 25'b0) begin
      $display("FAIL reset_discarded_write: got %h want 0", {s1_found, s1_index, s1_pfn});
      n_fail++;
    end
    n_checks++;
    if ({r_vpn2, r_asid, r_g, r_pfn0, r_pfn1} !== 68'b0) begin
      $display("FAIL reset_read: got %h want 0", {r_vpn2, r_asid, r_g, r_pfn0, r_pfn1});
      n_fail++;
    end
  endtask

  task automatic test_write_lookup();
    set_write(4'd3, 19'h12345, 8'h05, 1'b0, 20'hABCDE, 3'd3, 1'b1, 1'b1,
              20'h11111, 3'd2, 1'b0, 1'b0);
    s0_vpn2 = 19'h12345; s0_asid = 8'h05; s0_odd_page = 1'b0;
    #1;
    n_checks++;
    if (s0_found !== 1'b0) begin
      $display("FAIL write_cycle_old_contents: found=%b want 0", s0_found);
      n_fail++;
    end
    tick();
    we = 1'b0;
    #1;
    n_checks++;
    if ({s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v} !== {1'b1, 4'd3, 20'hABCDE, 3'd3, 1'b1, 1'b1}) begin
      $display("FAIL lookup_even: got %h want %h", {s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v},
               {1'b1, 4'd3, 20'hABCDE, 3'd3, 1'b1, 1'b1});
      n_fail++;
    end
    s0_odd_page = 1'b1;
    #1;
    n_checks++;
    if ({s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v} !== {1'b1, 4'd3, 20'h11111, 3'd2, 1'b0, 1'b0}) begin
      $display("FAIL lookup_odd: got %h want %h", {s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v},
               {1'b1, 4'd3, 20'h11111, 3'd2, 1'b0, 1'b0});
      n_fail++;
    end
  endtask

  task automatic test_asid_global();
    s0_vpn2 = 19'h12345; s0_asid = 8'h06; s0_odd_page = 1'b0;
    #1;
    n_checks++;
    if ({s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v} !== 30'b0) begin
      $display("FAIL asid_miss: got %h want 0", {s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v});
      n_fail++;
    end
    set_write(4'd3, 19'h12345, 8'h05, 1'b1, 20'hABCDE, 3'd3, 1'b1, 1'b1,
              20'h11111, 3'd2, 1'b0, 1'b0);
    tick();
    we = 1'b0;
    #1;
    n_checks++;
    if ({s0_found, s0_index} !== {1'b1, 4'd3}) begin
      $display("FAIL global_hit: got %h want 13", {s0_found, s0_index});
      n_fail++;
    end
  endtask

  task automatic test_probe();
    p_req = 1'b1; p_vpn2 = 19'h12345; p_asid = 8'h05;
    tick();
    p_req = 1'b0;
    n_checks++;
    if ({p_done, p_found, p_index} !== {1'b1, 1'b1, 4'd3}) begin
      $display("FAIL probe_hit: got %b want 110011", {p_done, p_found, p_index});
      n_fail++;
    end
    tick();
    n_checks++;
    if ({p_done, p_found, p_index} !== {1'b0, 1'b1, 4'd3}) begin
      $display("FAIL probe_hold: got %b want 010011", {p_done, p_found, p_index});
      n_fail++;
    end
    p_req = 1'b1; p_vpn2 = 19'h54321;
    tick();
    p_req = 1'b0;
    n_checks++;
    if ({p_done, p_found, p_index} !== {1'b1, 1'b0, 4'd0}) begin
      $display("FAIL probe_miss: got %b want 100000", {p_done, p_found, p_index});
      n_fail++;
    end
  endtask

  task automatic test_collision();
    set_write(4'd7, 19'h00777, 8'h10, 1'b0, 20'h00077, 3'd1, 1'b0, 1'b1,
              20'h00078, 3'd1, 1'b0, 1'b1);
    p_req = 1'b1; p_vpn2 = 19'h00777; p_asid = 8'h10;
    r_index = 4'd7;
    #1;
    n_checks++;
    if (r_vpn2 !== 19'h0) begin
      $display("FAIL read_pre_write: got %h want 0", r_vpn2);
      n_fail++;
    end
    tick();
    we = 1'b0;
    n_checks++;
    if ({p_done, p_found, p_index} !== {1'b1, 1'b0, 4'd0}) begin
      $display("FAIL collision_probe: got %b want 100000", {p_done, p_found, p_index});
      n_fail++;
    end
    tick();
    p_req = 1'b0;
    n_checks++;
    if ({p_done, p_found, p_index} !== {1'b1, 1'b1, 4'd7}) begin
      $display("FAIL collision_repeat: got %b want 110111", {p_done, p_found, p_index});
      n_fail++;
    end
  endtask

  task automatic test_duplicate();
    set_write(4'd9, 19'h2A2A2, 8'h33, 1'b0, 20'h00009, 3'd0, 1'b0, 1'b1,
              20'h00099, 3'd0, 1'b0, 1'b1);
    tick();
    set_write(4'd2, 19'h2A2A2, 8'h33, 1'b0, 20'h00002, 3'd0, 1'b0, 1'b1,
              20'h00022, 3'd0, 1'b0, 1'b1);
    tick();
    we = 1'b0;
    s1_vpn2 = 19'h2A2A2; s1_asid = 8'h33; s1_odd_page = 1'b0;
    p_req = 1'b1; p_vpn2 = 19'h2A2A2; p_asid = 8'h33;
    #1;
    n_checks++;
    if ({s1_found, s1_index, s1_pfn} !== {1'b1, 4'd2, 20'h00002}) begin
      $display("FAIL dup_lookup: got %h want %h", {s1_found, s1_index, s1_pfn}, {1'b1, 4'd2, 20'h00002});
      n_fail++;
    end
    tick();
    p_req = 1'b0;
    n_checks++;
    if ({p_done, p_found, p_index} !== {1'b1, 1'b1, 4'd2}) begin
      $display("FAIL dup_probe: got %b want 110010", {p_done, p_found, p_index});
      n_fail++;
    end
  endtask

  // Small vpn2/asid pools so that hits, globals and duplicates are frequent.
  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 1) == 1)
        set_write(4'($urandom), 19'($urandom_range(0, 5)), 8'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0), 20'($urandom), 3'($urandom), 1'($urandom),
                  1'($urandom), 20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
      else
        we = 1'b0;
      s0_vpn2 = 19'($urandom_range(0, 5)); s0_asid = 8'($urandom_range(0, 3));
      s0_odd_page = 1'($urandom);
      s1_vpn2 = 19'($urandom_range(0, 5)); s1_asid = 8'($urandom_range(0, 3));
      s1_odd_page = 1'($urandom);
      p_req = 1'($urandom);
      p_vpn2 = 19'($urandom_range(0, 5)); p_asid = 8'($urandom_range(0, 3));
      r_index = 4'($urandom);
      #1;
      n_checks++;
      if ({s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v} !== ref_lookup(s0_vpn2, s0_odd_page, s0_asid)) begin
        $display("FAIL rand_s0 iter %0d: got %h want %h", n,
                 {s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v}, ref_lookup(s0_vpn2, s0_odd_page, s0_asid));
        n_fail++;
      end
      n_checks++;
      if ({s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v} !== ref_lookup(s1_vpn2, s1_odd_page, s1_asid)) begin
        $display("FAIL rand_s1 iter %0d: got %h want %h", n,
                 {s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v}, ref_lookup(s1_vpn2, s1_odd_page, s1_asid));
        n_fail++;
      end
      n_checks++;
      if ({r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1} !== model[r_index]) begin
        $display("FAIL rand_read iter %0d: got %h want %h", n,
                 {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1}, model[r_index]);
        n_fail++;
      end
      tick();
      n_checks++;
      if ({p_done, p_found, p_index} !== {exp_p_done, exp_p_found, exp_p_index}) begin
        $display("FAIL rand_probe iter %0d: got %b want %b", n,
                 {p_done, p_found, p_index}, {exp_p_done, exp_p_found, exp_p_index});
        n_fail++;
      end
    end
    we = 1'b0;
    p_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_write(4'd3, 19'h12345, 8'h05, 1'b0, 20'hABCDE, 3'd3, 1'b1, 1'b1,
              20'h11111, 3'd2, 1'b0, 1'b0);
    tick();
    we = 1'b0;
    r_index = 4'd3;
    #1;
    n_checks++;
    if (r_vpn2 !== 19'h12345) begin
      $display("FAIL pre_reset_read: got %h want 12345", r_vpn2);
      n_fail++;
    end
    set_write(4'd3, 19'h0ABCD, 8'h07, 1'b1, 20'h12121, 3'd5, 1'b1, 1'b1,
              20'h34343, 3'd5, 1'b1, 1'b1);
    p_req = 1'b1; p_vpn2 = 19'h12345; p_asid = 8'h05;
    reset = 1'b1;
    tick();
    reset = 1'b0; we = 1'b0; p_req = 1'b0;
    s0_vpn2 = '0; s0_asid = '0; s0_odd_page = 1'b1;
    #1;
    n_checks++;
    if ({p_done, p_found, p_index} !== 6'b0) begin
      $display("FAIL reset_mid_probe: got %b want 000000", {p_done, p_found, p_index});
      n_fail++;
    end
    n_checks++;
    if ({r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1} !== '0) begin
      $display("FAIL reset_mid_read: got %h want 0",
               {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1});
      n_fail++;
    end
    n_checks++;
    if ({s0_found, s0_index, s0_v} !== {1'b1, 4'd0, 1'b0}) begin
      $display("FAIL reset_mid_lookup: got %b want 100000", {s0_found, s0_index, s0_v});
      n_fail++;
    end
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; p_req = 1'b0;
    w_index = '0; w_vpn2 = '0; w_asid = '0; w_g = 1'b0;
    w_pfn0 = '0; w_c0 = '0; w_d0 = 1'b0; w_v0 = 1'b0;
    w_pfn1 = '0; w_c1 = '0; w_d1 = 1'b0; w_v1 = 1'b0;
    s0_vpn2 = '0; s0_asid = '0; s0_odd_page = 1'b0;
    s1_vpn2 = '0; s1_asid = '0; s1_odd_page = 1'b0;
    p_vpn2 = '0; p_asid = '0; r_index = '0;
    exp_p_done = 1'b0; exp_p_found = 1'b0; exp_p_index = '0;
    for (int i = 0; i < 16; i++) model[i] = '0;

    test_reset();
    test_write_lookup();
    test_asid_global();
    test_probe();
    test_collision();
    test_duplicate();
    test_random();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mmu_tlb.md
MMU_TLB -- requirements
Module: mmu_tlb

Interface
REQ-001 SHALL have parameter TLBNUM, default 16, number of entries; the index width is 4 bits at the default.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have lookup port 0 (fetch) inputs s0_vpn2 [18:0], s0_odd_page [0], s0_asid [7:0].
REQ-005 SHALL have lookup port 0 outputs s0_found [0], s0_index [3:0], s0_pfn [19:0], s0_c [2:0], s0_d [0], s0_v [0].
REQ-006 SHALL have lookup port 1 (data) inputs and outputs identical in name pattern and width to port 0, with the s1_ prefix.
REQ-007 SHALL have probe port inputs p_req [0], p_vpn2 [18:0], p_asid [7:0].
REQ-008 SHALL have probe port outputs p_done [0], p_found [0], p_index [3:0]; these outputs are registered.
REQ-009 SHALL have write port inputs we [0], w_index [3:0], w_vpn2 [18:0], w_asid [7:0], w_g [0].
REQ-010 SHALL have write port inputs w_pfn0 [19:0], w_c0 [2:0], w_d0, w_v0, w_pfn1 [19:0], w_c1 [2:0], w_d1, w_v1.
REQ-011 SHALL have read port input r_index [3:0].
REQ-012 SHALL have read port outputs r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1, with the same widths as the write port.

Function
REQ-013 SHALL store TLBNUM entries, each holding {vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1}.
REQ-014 SHALL declare entry i matching a request when vpn2_i == req_vpn2 and (g_i == 1 or asid_i == req_asid).
REQ-015 SHALL make the s0/s1 lookups purely combinational, each in the same cycle as its request.
REQ-016 SHALL drive sN_found = 1 when any entry matches, and sN_index = the lowest matching index.
REQ-017 SHALL select the odd half (pfn1/c1/d1/v1) of the chosen entry when sN_odd_page = 1, otherwise the even half (pfn0/c0/d0/v0).
REQ-018 SHALL drive sN_found = 0 and sN_index/pfn/c/d/v = 0 when no entry matches.
REQ-019 SHALL report a match regardless of the V bit; V and D are passed through so the pipeline can raise TLB-invalid or Mod exceptions.
REQ-020 SHALL, on we = 1, overwrite entry w_index with all w_* fields at the clock edge.
REQ-021 SHALL make a write visible to lookups, probes and reads from the following cycle only; requests in the write cycle see the old contents.
REQ-022 SHALL implement the probe as a one-cycle pipeline: p_req sampled at edge k gives p_done = 1 for exactly the cycle after edge k.
REQ-023 SHALL, at that edge, capture p_found = any match and p_index = lowest matching index; p_index = 0 when nothing matches.
REQ-024 SHALL evaluate a probe against contents before any same-cycle write.
REQ-025 SHALL pulse p_done once per sampled p_req; back-to-back p_req pulses give back-to-back results, with no backpressure.
REQ-026 SHALL hold p_found and p_index stable while p_done = 0, until the next probe completes.
REQ-027 SHALL make the read port combinational: r_* = entry r_index, with pre-write contents when r_index == w_index in a write cycle.
REQ-028 SHALL treat all indices modulo TLBNUM; no out-of-range handling is required at TLBNUM = 16.
REQ-029 SHALL resolve multiple matching entries (software error) deterministically, by lowest index, with no X propagation.

Reset
REQ-030 SHALL, on reset = 1 at a clock edge, clear every field of every entry to 0.
REQ-031 SHALL, on that reset edge, clear p_done, p_found and p_index to 0.
REQ-032 SHALL give reset priority over a same-cycle we or p_req; both are discarded.
REQ-033 SHALL make all combinational outputs consistent with the all-zero entries after reset.
REQ-034 SHALL therefore make a lookup of vpn2 = 0 with asid = 0 after reset return found = 1, index = 0, v = 0.

Verification
REQ-035 SHALL pass write and lookup: write idx 3 {vpn2 = 0x12345, asid = 0x05, g = 0, pfn0 = 0xABCDE, v0 = 1, pfn1 = 0x11111, v1 = 0}; next cycle s0 (0x12345, odd = 0, asid = 5) -> found = 1, index = 3, pfn = 0xABCDE, v = 1; odd = 1 -> pfn = 0x11111, v = 0.
REQ-036 SHALL pass the ASID/global case: the same lookup with asid = 6 -> found = 0; rewrite idx 3 with g = 1, then asid = 6 -> found = 1.
REQ-037 SHALL pass the probe case: p_req with (0x12345, 5) -> next cycle p_done = 1, p_found = 1, p_index = 3; p_done = 0 the cycle after; a miss probe gives p_found = 0, p_index = 0.
REQ-038 SHALL pass write/probe collision: we to idx 7 with vpn2 = 0x00777 and p_req for 0x00777 in the same cycle -> p_found = 0; a repeat probe -> p_found = 1, p_index = 7.
REQ-039 SHALL pass the duplicate-match case: identical vpn2/asid written to idx 9 and idx 2 -> s1_index = 2 and p_index = 2.
REQ-040 SHALL pass reset mid-operation: reset asserted together with we and p_req -> p_done = 0 next cycle, and r_index = 3 reads all zeros.
